aes_coproc_sequencer: RTL and testbench

//  Sequences custom-0 (opcode 7'b0001011) AES instructions between the decode stage and the AES core.

---
 rtl/aes_coproc_sequencer_if.sv | 41 ++++
 rtl/aes_coproc_sequencer.sv | 129 ++++++++++++
 tb/tb_aes_coproc_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_coproc_sequencer_if.sv
// Decode/core/writeback-side signal bundle for the AES custom-0 instruction sequencer.
// The sequencer takes the slave view; the surrounding pipeline takes the master view.
interface aes_coproc_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            issue_valid;
    logic [2:0]      issue_funct;
    logic [4:0]      issue_rd;
    logic [XLEN-1:0] issue_rs1_val;
    logic [XLEN-1:0] issue_rs2_val;
    logic            kill;

    logic            aes_start;
    logic [2:0]      aes_op;
    logic [XLEN-1:0] aes_din_a;
    logic [XLEN-1:0] aes_din_b;
    logic            aes_core_done;
    logic [XLEN-1:0] aes_core_result;

    logic            wb_pipe_valid;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    logic            aes_done;
    logic            aes_err;

    modport slave (
        input  issue_valid, issue_funct, issue_rd, issue_rs1_val, issue_rs2_val, kill,
        input  aes_core_done, aes_core_result, wb_pipe_valid,
        output aes_start, aes_op, aes_din_a, aes_din_b,
        output rf_we, rf_waddr, rf_wdata, aes_done, aes_err
    );

    modport master (
        output issue_valid, issue_funct, issue_rd, issue_rs1_val, issue_rs2_val, kill,
        output aes_core_done, aes_core_result, wb_pipe_valid,
        input  aes_start, aes_op, aes_din_a, aes_din_b,
        input  rf_we, rf_waddr, rf_wdata, aes_done, aes_err
    );
endinterface

// File: rtl/aes_coproc_sequencer.sv
// Launches one AES core operation per custom-0 instruction, waits with a timeout, and
// writes the result back through the shared RF port when the pipeline leaves it free.
module aes_coproc_sequencer #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input logic                   clk,
    input logic                   nrst,
    aes_coproc_sequencer_if.slave bus_io
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StLaunch, StWait, StWb, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        funct_q, funct_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              abort_q, abort_d;
    logic              err_q, err_d;
    logic              accept;
    logic              abort_now;
    logic              timed_out;

    assign accept    = (state_q == StIdle) && bus_io.issue_valid && !bus_io.kill;
    // A kill in the same cycle as completion still suppresses the write.
    assign abort_now = abort_q || bus_io.kill;
    assign timed_out = (cnt_q == CntLast);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StLaunch;
            StLaunch: state_d = StWait;
            StWait: begin
                if (bus_io.aes_core_done) begin
                    state_d = (!abort_now && (rd_q != 5'd0)) ? StWb : StDone;
                end else if (timed_out) begin
                    state_d = StDone;
                end
            end
            StWb:     if (!bus_io.wb_pipe_valid) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        funct_d  = funct_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        err_d    = err_q;
        if (accept) begin
            funct_d = bus_io.issue_funct;
            rd_d    = bus_io.issue_rd;
            a_d     = bus_io.issue_rs1_val;
            b_d     = bus_io.issue_rs2_val;
        end
        unique case (state_q)
            StLaunch: begin
                cnt_d   = '0;
                abort_d = abort_now;
            end
            StWait: begin
                cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
                abort_d = abort_now;
                if (bus_io.aes_core_done) begin
                    result_d = bus_io.aes_core_result;
                end else if (timed_out) begin
                    err_d = 1'b1;
                end
            end
            StDone:  abort_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            funct_q  <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            funct_q  <= funct_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
        end
    end

    // Pipeline writeback wins the shared port; rf_we doubles as the RF mux select.
    always_comb begin
        bus_io.aes_start = (state_q == StLaunch);
        bus_io.aes_done  = (state_q == StDone);
        bus_io.rf_we     = (state_q == StWb) && !bus_io.wb_pipe_valid;
        bus_io.rf_waddr  = bus_io.rf_we ? rd_q : 5'd0;
        bus_io.rf_wdata  = bus_io.rf_we ? result_q : '0;
        bus_io.aes_op    = funct_q;
        bus_io.aes_din_a = a_q;
        bus_io.aes_din_b = b_q;
        bus_io.aes_err   = err_q;
    end
endmodule

// File: tb/tb_aes_coproc_sequencer.sv
// Self-checking bench: vector table of AES ops with a write scoreboard, plus hand sequences
// for timeout, stray completions and mid-operation reset.
module tb_aes_coproc_sequencer;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 64;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    aes_coproc_sequencer_if #(.XLEN(XLEN)) bus ();

    aes_coproc_sequencer #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .bus_io(bus)
    );

    typedef struct {
        logic [2:0]  funct;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
        int          stall;
        int          kill_k;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    vec_t vecs[6];
    int   n_vec = 0;
    int   n_bad = 0;
    logic exp_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctrl"}, 64'({bus.aes_start, bus.rf_we, bus.aes_done, bus.aes_err}), 64'd0);
        check({name, "_op"}, 64'(bus.aes_op), 64'd0);
        check({name, "_din_a"}, 64'(bus.aes_din_a), 64'd0);
        check({name, "_din_b"}, 64'(bus.aes_din_b), 64'd0);
        check({name, "_wb"}, 64'({bus.rf_waddr, bus.rf_wdata}), 64'd0);
    endtask

    task automatic issue(input logic [2:0] funct, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        bus.issue_valid   = 1'b1;
        bus.issue_funct   = funct;
        bus.issue_rd      = rd;
        bus.issue_rs1_val = a;
        bus.issue_rs2_val = b;
    endtask

    // Issue one op, model the core with latency v.lat, and score the writeback/done timing.
    task automatic run_op(input vec_t v);
        int  done_c;
        int  we_c;
        int  n_we;
        bit  writes;
        wr_t w;
        wr_t got;
        writes = (v.rd != 5'd0) && (v.kill_k == 0);
        @(negedge clk);
        issue(v.funct, v.rd, v.a, v.b);
        if (writes) begin
            w.addr = v.rd;
            w.data = v.res;
            exp_q.push_back(w);
        end
        @(negedge clk);
        check("aes_start", 64'(bus.aes_start), 64'd1);
        check("aes_op", 64'(bus.aes_op), 64'(v.funct));
        check("aes_din_a", 64'(bus.aes_din_a), 64'(v.a));
        check("aes_din_b", 64'(bus.aes_din_b), 64'(v.b));
        bus.issue_valid = 1'b0;
        for (int k = 1; k <= v.lat; k++) begin
            @(negedge clk);
            check("wait_quiet", 64'({bus.aes_start, bus.rf_we, bus.aes_done}), 64'd0);
            bus.kill = (k == v.kill_k);
            if (k == v.lat) begin
                bus.aes_core_done   = 1'b1;
                bus.aes_core_result = v.res;
            end
        end
        done_c = -1;
        we_c   = -1;
        n_we   = 0;
        for (int c = 0; c < 24 && done_c < 0; c++) begin
            @(negedge clk);
            bus.aes_core_done   = 1'b0;
            bus.aes_core_result = '0;
            bus.kill            = 1'b0;
            bus.wb_pipe_valid   = (c < v.stall);
            #1;
            if (bus.rf_we) begin
                n_we++;
                we_c = c;
                if (exp_q.size() == 0) begin
                    check("rf_we_unexpected", 64'(bus.rf_we), 64'd0);
                end else begin
                    got = exp_q.pop_front();
                    check("rf_waddr", 64'(bus.rf_waddr), 64'(got.addr));
                    check("rf_wdata", 64'(bus.rf_wdata), 64'(got.data));
                end
            end
            if (bus.aes_done) done_c = c;
        end
        bus.wb_pipe_valid = 1'b0;
        check("write_count", 64'(n_we), 64'(writes));
        if (writes) check("rf_we_cycle", 64'(we_c), 64'(v.stall));
        check("done_cycle", 64'(done_c), 64'(writes ? v.stall + 1 : 0));
        check("aes_err", 64'(bus.aes_err), 64'(exp_err));
        @(negedge clk);
        check("done_pulse", 64'({bus.aes_done, bus.rf_we}), 64'd0);
    endtask

    initial begin
        int found;
        vecs[0] = '{3'd1, 5'd5,  32'h0011_2233, 32'h4455_6677, 4, 32'hCAFE_F00D, 0, 0};
        vecs[1] = '{3'd2, 5'd5,  32'h0011_2233, 32'h4455_6677, 4, 32'hCAFE_F00D, 3, 0};
        vecs[2] = '{3'd3, 5'd0,  32'h89AB_CDEF, 32'h0123_4567, 4, 32'h1234_5678, 0, 0};
        vecs[3] = '{3'd4, 5'd12, 32'h1357_9BDF, 32'h2468_ACE0, 6, 32'hDEAD_BEEF, 0, 2};
        vecs[4] = '{3'd5, 5'd31, 32'hFFFF_0000, 32'h0000_FFFF, 1, 32'hA5A5_5A5A, 1, 0};
        vecs[5] = '{3'd7, 5'd1,  32'h7777_8888, 32'h9999_AAAA, 9, 32'h0F0F_0F0F, 0, 0};

        nrst                = 1'b0;
        bus.issue_valid     = 1'b0;
        bus.issue_funct     = '0;
        bus.issue_rd        = '0;
        bus.issue_rs1_val   = '0;
        bus.issue_rs2_val   = '0;
        bus.kill            = 1'b0;
        bus.aes_core_done   = 1'b0;
        bus.aes_core_result = '0;
        bus.wb_pipe_valid   = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        nrst = 1'b1;

        // Stray completion while idle must not start, write or signal done.
        @(negedge clk);
        bus.aes_core_done   = 1'b1;
        bus.aes_core_result = 32'h5555_AAAA;
        @(negedge clk);
        bus.aes_core_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_done", 64'({bus.aes_start, bus.rf_we, bus.aes_done}), 64'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        // Core never completes: timeout after TIMEOUT cycles in WAIT, sticky error.
        @(negedge clk);
        issue(3'd6, 5'd7, 32'h1111_1111, 32'h2222_2222);
        @(negedge clk);
        check("to_start", 64'(bus.aes_start), 64'd1);
        bus.issue_valid = 1'b0;
        found = -1;
        for (int t = 1; t <= 100 && found < 0; t++) begin
            @(negedge clk);
            if (bus.rf_we) check("to_no_write", 64'(bus.rf_we), 64'd0);
            if (t == TIMEOUT) check("to_err_early", 64'(bus.aes_err), 64'd0);
            if (bus.aes_done) begin
                found = t;
                check("to_err", 64'(bus.aes_err), 64'd1);
            end
        end
        check("to_done_cycle", 64'(found), 64'(TIMEOUT + 1));
        exp_err = 1'b1;
        run_op(vecs[0]);

        // Reset in the middle of WAIT drops the op and clears the error flag.
        @(negedge clk);
        issue(3'd2, 5'd9, 32'hABCD_0123, 32'h4567_89AB);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        nrst    = 1'b1;
        exp_err = 1'b0;
        bus.aes_core_done   = 1'b1;
        bus.aes_core_result = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.aes_core_done = 1'b0;
        check("post_rst_quiet", 64'({bus.aes_start, bus.rf_we, bus.aes_done}), 64'd0);
        run_op(vecs[4]);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
